// File: rtl/udma_spim_cmd_dispatch_if.sv
// Command-word handshake bundle between the uDMA cmd channel, the dispatcher and the SPI controller.
// The slave modport is the dispatcher's view; master is the surrounding channel/controller.
interface udma_spim_cmd_dispatch_if;
    logic [31:0] data_i;
    logic        data_valid_i;
    logic        data_ready_o;
    logic [31:0] udma_cmd_o;
    logic        udma_cmd_valid_o;
    logic        udma_cmd_ready_o;
    logic        ctrl_ready_i;

    modport slave (
        input  data_i, data_valid_i, ctrl_ready_i,
        output data_ready_o, udma_cmd_o, udma_cmd_valid_o, udma_cmd_ready_o
    );

    modport master (
        output data_i, data_valid_i, ctrl_ready_i,
        input  data_ready_o, udma_cmd_o, udma_cmd_valid_o, udma_cmd_ready_o
    );
endinterface

// File: rtl/udma_spim_cmd_dispatch.sv
// SPI-master command dispatcher: registered FIFO, head visible one cycle after push; setup words pop at once.
// Backpressure: data_ready_o drops only when full (no pop-side path); non-setup words wait for ctrl_ready_i.
module udma_spim_cmd_dispatch #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       cfg_clr_i,
    udma_spim_cmd_dispatch_if.slave    bus,
    output logic                       eot_o,
    output logic [$clog2(DEPTH):0]     fill_o,
    output logic [CNT_WIDTH-1:0]       cmd_cnt_o
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned FILL_W = AW + 1;
    localparam logic [FILL_W-1:0] FULL = FILL_W'(DEPTH);

    localparam logic [3:0] OP_SETUP_UCA = 4'hD;
    localparam logic [3:0] OP_SETUP_UCS = 4'hE;
    localparam logic [3:0] OP_EOT       = 4'h9;

    typedef enum logic {S_RUN, S_EOT} state_e;

    state_e              state_q, state_d;
    logic [31:0]         mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [FILL_W-1:0]   fill_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic [31:0] head;
    logic [3:0]  head_op;
    logic        not_empty, is_setup, is_eot;
    logic        push, pop, run;

    assign head      = mem_q[rd_ptr_q];
    assign head_op   = head[31:28];
    assign not_empty = (fill_q != '0);
    assign is_setup  = (head_op == OP_SETUP_UCA) || (head_op == OP_SETUP_UCS);
    assign is_eot    = (head_op == OP_EOT);

    assign bus.data_ready_o     = (fill_q != FULL);
    assign bus.udma_cmd_o       = not_empty ? head : 32'h0;
    assign bus.udma_cmd_valid_o = not_empty & run;
    assign bus.udma_cmd_ready_o = bus.udma_cmd_valid_o & (is_setup | bus.ctrl_ready_i);

    assign push = bus.data_valid_i & bus.data_ready_o;
    assign pop  = bus.udma_cmd_valid_o & bus.udma_cmd_ready_o;

    assign fill_o    = fill_q;
    assign cmd_cnt_o = cnt_q;

    // FSM: state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)          state_q <= S_RUN;
        else if (cfg_clr_i) state_q <= S_RUN;
        else                state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (pop && is_eot) state_d = S_EOT;
            S_EOT:   state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    // FSM: outputs; eot_o comes straight from the state flop so the pulse is glitch-free
    always_comb begin
        run   = (state_q == S_RUN);
        eot_o = (state_q == S_EOT);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            cnt_q    <= '0;
        end else if (cfg_clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   fill_q <= fill_q + FILL_W'(1);
                2'b01:   fill_q <= fill_q - FILL_W'(1);
                default: fill_q <= fill_q;
            endcase
            if (pop && !is_setup && !is_eot) cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    // Storage needs no reset: reads are masked to zero while empty.
    always_ff @(posedge clk_i) begin
        if (push && !cfg_clr_i) mem_q[wr_ptr_q] <= bus.data_i;
    end

endmodule

// File: tb/tb_udma_spim_cmd_dispatch.sv
// Directed bench for udma_spim_cmd_dispatch: inputs change 2ns after the rising edge, checks follow.
module tb_udma_spim_cmd_dispatch;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cfg_clr_i = 1'b0;
    logic        eot_o;
    logic [2:0]  fill_o;
    logic [15:0] cmd_cnt_o;

    int n_chk = 0;
    int n_err = 0;

    udma_spim_cmd_dispatch_if bus ();

    udma_spim_cmd_dispatch #(.DEPTH(4), .CNT_WIDTH(16)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .cfg_clr_i (cfg_clr_i),
        .bus       (bus.slave),
        .eot_o     (eot_o),
        .fill_o    (fill_o),
        .cmd_cnt_o (cmd_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    initial begin
        bus.data_i       = 32'h0;
        bus.data_valid_i = 1'b0;
        bus.ctrl_ready_i = 1'b0;

        // reset
        #12;
        chk("rst_fill",  32'(fill_o), 0);
        chk("rst_valid", 32'(bus.udma_cmd_valid_o), 0);
        chk("rst_eot",   32'(eot_o), 0);
        chk("rst_cnt",   32'(cmd_cnt_o), 0);
        chk("rst_cmd",   bus.udma_cmd_o, 0);
        rst_i = 1'b0;
        #1;
        chk("rst_drdy",  32'(bus.data_ready_o), 1);

        // setup word pops without the controller
        step();
        bus.data_i = 32'hD000_0100; bus.data_valid_i = 1'b1;
        #1;
        chk("setup_no_bypass", 32'(bus.udma_cmd_valid_o), 0);
        step();
        bus.data_valid_i = 1'b0;
        chk("setup_valid", 32'(bus.udma_cmd_valid_o), 1);
        chk("setup_cmd",   bus.udma_cmd_o, 32'hD000_0100);
        chk("setup_rdy",   32'(bus.udma_cmd_ready_o), 1);
        step();
        chk("setup_fill",  32'(fill_o), 0);
        chk("setup_cnt",   32'(cmd_cnt_o), 0);

        // controller stall
        bus.data_i = 32'h1000_0007; bus.data_valid_i = 1'b1;
        step();
        bus.data_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(bus.udma_cmd_valid_o), 1);
            chk("stall_cmd",   bus.udma_cmd_o, 32'h1000_0007);
            chk("stall_rdy",   32'(bus.udma_cmd_ready_o), 0);
            step();
        end
        bus.ctrl_ready_i = 1'b1;
        #1;
        chk("stall_release_rdy", 32'(bus.udma_cmd_ready_o), 1);
        step();
        bus.ctrl_ready_i = 1'b0;
        chk("stall_fill", 32'(fill_o), 0);
        chk("stall_cnt",  32'(cmd_cnt_o), 1);

        // fill to DEPTH, then drain while pushing across the pointer wrap
        bus.data_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.data_i = 32'h1000_00A0 + 32'(i);
            step();
        end
        bus.data_i = 32'h1000_00B0;
        chk("full_fill", 32'(fill_o), 4);
        chk("full_drdy", 32'(bus.data_ready_o), 0);
        bus.ctrl_ready_i = 1'b1;
        #1;
        chk("full_cmd0", bus.udma_cmd_o, 32'h1000_00A0);
        chk("full_drdy_pop", 32'(bus.data_ready_o), 0);
        step();
        chk("drain_fill1", 32'(fill_o), 3);
        chk("drain_drdy",  32'(bus.data_ready_o), 1);
        chk("drain_cmd1",  bus.udma_cmd_o, 32'h1000_00A1);
        step();
        bus.data_i = 32'h1000_00B1;
        chk("drain_fill2", 32'(fill_o), 3);
        chk("drain_cmd2",  bus.udma_cmd_o, 32'h1000_00A2);
        step();
        bus.data_valid_i = 1'b0;
        chk("drain_fill3", 32'(fill_o), 3);
        chk("drain_cmd3",  bus.udma_cmd_o, 32'h1000_00A3);
        step();
        chk("drain_fill4", 32'(fill_o), 2);
        chk("wrap_cmd_b0", bus.udma_cmd_o, 32'h1000_00B0);
        step();
        chk("drain_fill5", 32'(fill_o), 1);
        chk("wrap_cmd_b1", bus.udma_cmd_o, 32'h1000_00B1);
        step();
        chk("drain_empty", 32'(fill_o), 0);
        chk("drain_cnt",   32'(cmd_cnt_o), 7);
        chk("empty_cmd",   bus.udma_cmd_o, 0);

        // EOT pulse
        bus.data_i = 32'h9000_0000; bus.data_valid_i = 1'b1;
        step();
        bus.data_i = 32'h1000_0001;
        chk("eot_head", bus.udma_cmd_o, 32'h9000_0000);
        chk("eot_pre",  32'(eot_o), 0);
        step();
        bus.data_valid_i = 1'b0;
        chk("eot_pulse",     32'(eot_o), 1);
        chk("eot_valid_off", 32'(bus.udma_cmd_valid_o), 0);
        chk("eot_fill",      32'(fill_o), 1);
        step();
        chk("eot_end",    32'(eot_o), 0);
        chk("eot_next_v", 32'(bus.udma_cmd_valid_o), 1);
        chk("eot_next_c", bus.udma_cmd_o, 32'h1000_0001);
        step();
        bus.ctrl_ready_i = 1'b0;
        chk("eot_cnt",  32'(cmd_cnt_o), 8);
        chk("eot_once", 32'(eot_o), 0);

        // flush with a push in the same cycle
        bus.data_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.data_i = 32'h1000_00C0 + 32'(i);
            step();
        end
        chk("flush_pre_fill", 32'(fill_o), 3);
        bus.data_i = 32'h1000_00C3;
        cfg_clr_i = 1'b1;
        step();
        cfg_clr_i = 1'b0;
        bus.data_valid_i = 1'b0;
        chk("flush_fill",  32'(fill_o), 0);
        chk("flush_cnt",   32'(cmd_cnt_o), 0);
        chk("flush_valid", 32'(bus.udma_cmd_valid_o), 0);
        chk("flush_eot",   32'(eot_o), 0);
        step();
        chk("flush_dropped", 32'(fill_o), 0);

        // asynchronous reset mid-operation
        bus.data_i = 32'h1000_00D0; bus.data_valid_i = 1'b1;
        step();
        bus.data_valid_i = 1'b0;
        chk("arst_pre_fill", 32'(fill_o), 1);
        rst_i = 1'b1;
        #1;
        chk("arst_fill",  32'(fill_o), 0);
        chk("arst_valid", 32'(bus.udma_cmd_valid_o), 0);
        chk("arst_cmd",   bus.udma_cmd_o, 0);
        rst_i = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
